bus_master_port: RTL

Master-side serial initiator for the system bus, sitting directly upstream of the address decoder. It accepts one parallel read/write request from a local user and serialises it onto the one-bit bus (`mwdata`/`mvalid`). Transmission order is: device address, then a one-cycle ack window, then mode, memory address and write data. For reads it deserialises the slave's returned word. It then releases the bus and reports completion or error to the user.

---
 rtl/bus_pkg.sv | 27 ++
 rtl/serial_shift.sv | 51 +++++
 rtl/bus_master_port.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus: default widths, mode bit values
// and the initiator FSM state type.
package bus_pkg;

    localparam int unsigned DEF_ADDR_WIDTH        = 16;
    localparam int unsigned DEF_DEVICE_ADDR_WIDTH = 4;
    localparam int unsigned DEF_DATA_WIDTH        = 8;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DADDR,
        ST_ACKW,
        ST_PAYLOAD,
        ST_RDWAIT,
        ST_RDATA,
        ST_DONE
    } state_e;

    // Width of a counter that must be able to hold the value n.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/serial_shift.sv
// LSB-first shift register usable as PISO (parallel load, serial out at bit 0)
// or SIPO (serial in at the MSB end), with a count of shifts since load.
module serial_shift
    import bus_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       load,
    input  logic                       shift,
    input  logic                       sin,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dnext,
    output logic [cnt_w(WIDTH)-1:0]    cnt,
    output logic                       last
);

    localparam int unsigned CW = cnt_w(WIDTH);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load) begin
            sr_d  = din;
            cnt_d = '0;
        end else if (shift) begin
            sr_d  = {sin, sr_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    // Next-cycle contents let the owner register its outputs without a cycle of lag.
    assign dnext = sr_d;
    assign cnt   = cnt_q;
    assign last  = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/bus_master_port.sv
// Serial bus initiator: serialises one user read/write request onto mwdata/mvalid,
// collects read data from the slave and reports completion or error.
module bus_master_port
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH        = DEF_ADDR_WIDTH,
    parameter int unsigned DEVICE_ADDR_WIDTH = DEF_DEVICE_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int unsigned RD_TIMEOUT        = 255
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  dvalid,
    output logic                  dready,
    input  logic                  dmode,
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic [DATA_WIDTH-1:0] dwdata,
    output logic [DATA_WIDTH-1:0] drdata,
    output logic                  ddone,
    output logic                  derr,
    output logic                  mwdata,
    output logic                  mvalid,
    input  logic                  ack,
    input  logic                  srdata,
    input  logic                  svalid
);

    localparam int unsigned MADDR_W = ADDR_WIDTH - DEVICE_ADDR_WIDTH;
    localparam int unsigned TX_W    = ADDR_WIDTH + 1 + DATA_WIDTH;
    localparam int unsigned TX_CW   = cnt_w(TX_W);
    localparam int unsigned RX_CW   = cnt_w(DATA_WIDTH);
    localparam int unsigned TO_W    = cnt_w(RD_TIMEOUT);

    state_e                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [TO_W-1:0]       wait_q, wait_d;
    logic                  abort;
    logic                  mvalid_q, mvalid_d;
    logic                  mwdata_q, mwdata_d;
    logic                  ddone_q, ddone_d;
    logic                  derr_q, derr_d;
    logic [DATA_WIDTH-1:0] drdata_q, drdata_d;

    logic                  accept, tx_shift, rx_shift, tx_last, rx_last;
    logic [TX_W-1:0]       tx_vec, tx_next;
    logic [TX_CW-1:0]      tx_cnt;
    logic [DATA_WIDTH-1:0] rx_next;
    logic [RX_CW-1:0]      rx_cnt;
    logic                  unused_bits;

    assign dready   = (state_q == ST_IDLE);
    assign accept   = dvalid & dready;
    // One frame, LSB first: device bits, mode, memory address, write data.
    // The ACKW cycle sits between device bits and mode by pausing the shifter.
    assign tx_vec   = {dwdata, daddr[MADDR_W-1:0], dmode,
                       daddr[ADDR_WIDTH-1 -: DEVICE_ADDR_WIDTH]};
    assign tx_shift = (state_q == ST_DADDR) || (state_q == ST_PAYLOAD);
    assign rx_shift = svalid && ((state_q == ST_RDWAIT) || (state_q == ST_RDATA));

    serial_shift #(.WIDTH(TX_W)) u_tx (
        .clk   (clk),
        .rstn  (rstn),
        .load  (accept),
        .shift (tx_shift),
        .sin   (1'b0),
        .din   (tx_vec),
        .dnext (tx_next),
        .cnt   (tx_cnt),
        .last  (tx_last)
    );

    serial_shift #(.WIDTH(DATA_WIDTH)) u_rx (
        .clk   (clk),
        .rstn  (rstn),
        .load  (accept),
        .shift (rx_shift),
        .sin   (srdata),
        .din   ('0),
        .dnext (rx_next),
        .cnt   (rx_cnt),
        .last  (rx_last)
    );

    assign unused_bits = ^{tx_next[TX_W-1:1], rx_cnt};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_READ;
            wait_q   <= '0;
            mvalid_q <= 1'b0;
            mwdata_q <= 1'b0;
            ddone_q  <= 1'b0;
            derr_q   <= 1'b0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            wait_q   <= wait_d;
            mvalid_q <= mvalid_d;
            mwdata_q <= mwdata_d;
            ddone_q  <= ddone_d;
            derr_q   <= derr_d;
            drdata_q <= drdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        wait_d  = wait_q;
        abort   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_DADDR;
                    mode_d  = dmode;
                end
            end
            ST_DADDR: begin
                if (tx_cnt == TX_CW'(DEVICE_ADDR_WIDTH - 1)) state_d = ST_ACKW;
            end
            ST_ACKW: begin
                if (ack) begin
                    state_d = ST_PAYLOAD;
                end else begin
                    state_d = ST_DONE;
                    abort   = 1'b1;
                end
            end
            ST_PAYLOAD: begin
                wait_d = '0;
                if (mode_q == MODE_WRITE) begin
                    if (tx_last) state_d = ST_DONE;
                end else if (tx_cnt == TX_CW'(DEVICE_ADDR_WIDTH + MADDR_W)) begin
                    state_d = ST_RDWAIT;
                end
            end
            ST_RDWAIT: begin
                if (svalid) begin
                    state_d = ST_RDATA;
                end else if ((RD_TIMEOUT != 0) && (wait_q == TO_W'(RD_TIMEOUT - 1))) begin
                    state_d = ST_DONE;
                    abort   = 1'b1;
                end else begin
                    wait_d = wait_q + TO_W'(1);
                end
            end
            ST_RDATA: begin
                if (svalid && rx_last) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the state being entered.
    always_comb begin
        mvalid_d = (state_d == ST_DADDR) || (state_d == ST_ACKW) || (state_d == ST_PAYLOAD)
                || (state_d == ST_RDWAIT) || (state_d == ST_RDATA);
        mwdata_d = ((state_d == ST_DADDR) || (state_d == ST_PAYLOAD)) ? tx_next[0] : 1'b0;
        ddone_d  = (state_d == ST_DONE);
        derr_d   = (state_d == ST_DONE) && abort;
        drdata_d = drdata_q;
        if ((state_q == ST_RDATA) && (state_d == ST_DONE)) drdata_d = rx_next;
    end

    assign mvalid = mvalid_q;
    assign mwdata = mwdata_q;
    assign ddone  = ddone_q;
    assign derr   = derr_q;
    assign drdata = drdata_q;

endmodule
